controle_sequenciador: RTL
==========================

# controle_sequenciador

Multi-cycle control FSM for the 9-bit processor datapath (R0..R7, A, G, add/sub ALU, shared bus). It owns the step counter, program counter and a private instruction register. It fetches instructions from the program memory and drives every bus and register enable cycle by cycle. It sits between the memory (`ADDR` out, `DIN` in) and the register/ALU datapath, and replaces the external step counter and the Run edge logic.

## Interface
- `ADDR_W`, default 5: program-counter width; memory depth is 2^ADDR_W words.
- `Clock` in 1: single system clock; all state updates on the rising edge.
- `Resetn` in 1: reset, asynchronous, active-low.
- `Run` in 1: level request to execute instructions.
- `DIN` in 9: memory data at `ADDR`, valid in the same cycle (asynchronous-read memory).
- `ADDR` out ADDR_W: program counter.
- `Tstep` out 2: current step (00=T0 … 11=T3); 00 while idle.
- `Busy` out 1: high in any state except IDLE.
- `IRin`, `DINout`, `Ain`, `Gin`, `Gout`, `AddSub`, `Done` out 1 each: datapath controls.
- `Rin` out 8: one-hot register write enables for R0..R7.
- `Rout` out 8: one-hot register read enables for R0..R7.

## Operation
- Instruction word fields: `opcode=[8:6]`, `Rx=[5:3]` (destination), `Ry=[2:0]` (source).
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100..111 nop.
- States: IDLE, T0, T1, T2, T3.
- All control outputs are combinational decodes of state plus the internal IR. Every output is 0 in IDLE and in any step not listed below.
- Decoding uses 3-to-8 one-hot for Rx and Ry, and `Rout` is never multi-hot. Only one bus driver is active per cycle: a register via `Rout`, or `DINout`, or `Gout`.
- IDLE: when `Run`=1 is sampled, go to T0.
- T0 (fetch): `IRin`=1, `DINout`=1. The internal IR loads `DIN` and `ADDR` increments. Go to T1.
- T1, mv: `Rout`=dec(Ry), `Rin`=dec(Rx), `Done`=1.
- T1, mvi: `DINout`=1, `Rin`=dec(Rx), `Done`=1. `ADDR` increments past the immediate word.
- T1, add/sub: `Rout`=dec(Rx), `Ain`=1. Go to T2.
- T1, nop: `Done`=1.
- T2, add/sub: `Rout`=dec(Ry), `Gin`=1. `AddSub`=0 for add, 1 for sub. Go to T3.
- T3, add/sub: `Gout`=1, `Rin`=dec(Rx), `Done`=1.
- After any `Done` cycle: go to T0 if `Run`=1, otherwise go to IDLE.
- `Run` is sampled only in IDLE and in `Done` cycles. Dropping `Run` mid-instruction never aborts the instruction in progress.
- `ADDR` is a modulo-2^ADDR_W counter: 2^ADDR_W−1 + 1 wraps to 0, with no flag.
- Rx=Ry is legal. For mv it is a no-op copy. For add/sub the result is R+R or 0.

## Timing
- Reset: asynchronous. On `Resetn`=0 the block enters IDLE immediately and sets IR=0, `ADDR`=0, `Tstep`=00, `Busy`=0, and all controls to 0, without waiting for a clock edge.
- Reset mid-instruction aborts with no `Done`. After release, execution restarts from `ADDR`=0.
- Reset release: the first transition out of IDLE happens on the first rising edge where `Run`=1.
- Latency from IDLE: T0 is entered one edge after `Run`=1 is sampled.
- Instruction length: mv/mvi/nop take 2 cycles (T0, T1); add/sub take 4 cycles (T0..T3).
- Back-to-back: with `Run` held at 1, the next T0 immediately follows the `Done` cycle, with no idle bubble.
- `Done` is a single-cycle pulse, exactly one per completed instruction.
- `ADDR` updates on the edge that ends T0, and on the edge that ends T1 for mvi only.
- `Tstep` equals the state encoding: T0=00, T1=01, T2=10, T3=11.

## Test plan
- Reset: assert `Resetn`=0 mid-T2 of an add → in the same cycle all outputs are 0 and `ADDR`=0. After release with `Run`=0, the block stays IDLE and `Busy`=0.
- mvi: memory[0]=001_011_000, memory[1]=0x1A5, `Run`=1 → T0 has `IRin`=`DINout`=1; T1 has `DINout`=1, `Rin`=0000_1000, `Done`=1; `ADDR`=2 afterwards.
- mv: instruction 000_101_010 → T1 has `Rout`=0000_0100, `Rin`=0010_0000, `Done`=1; 2 cycles total.
- add then sub back-to-back: 010_001_010 then 011_001_010 with `Run` held at 1 → T1: `Rout`=0000_0010, `Ain`=1. T2: `Rout`=0000_0100, `Gin`=1, with `AddSub`=0 for the add and 1 for the sub. T3: `Gout`=1, `Rin`=0000_0010, `Done`=1. The second T0 directly follows the first `Done`; total 8 cycles.
- `Run` dropped during T1 of an add → T2 and T3 still execute and `Done` pulses, then the block goes to IDLE and `ADDR` holds.
- Wrap: `ADDR_W`=2, four nops with `Run`=1 → `ADDR` runs 1,2,3,0 and a fetch occurs from address 0 again.

Source files
------------

// File: rtl/controle_sequenciador.sv
// Multi-cycle control sequencer for the 9-bit datapath: it fetches from the
// program memory, holds a private IR and drives the bus and register enables for each step.
module controle_sequenciador #(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [8:0]        DIN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [1:0]        Tstep,
    output logic              Busy,
    output logic              IRin,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              AddSub,
    output logic              Done,
    output logic [7:0]        Rin,
    output logic [7:0]        Rout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t            state_q, state_d;
    logic [8:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [2:0] opcode;
    logic [7:0] rx_dec;
    logic [7:0] ry_dec;

    assign opcode = ir_q[8:6];

    // One-hot decodes of the destination and source fields
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign rx_dec[gi] = (ir_q[5:3] == 3'(gi));
            assign ry_dec[gi] = (ir_q[2:0] == 3'(gi));
        end
    endgenerate

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            ir_q    <= 9'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        IRin    = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        Rin     = 8'd0;
        Rout    = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_T0;
            end
            S_T0: begin
                IRin    = 1'b1;
                DINout  = 1'b1;
                ir_d    = DIN;
                addr_d  = addr_q + 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout = ry_dec;
                        Rin  = rx_dec;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        // DIN now holds the immediate word; step past it
                        DINout = 1'b1;
                        Rin    = rx_dec;
                        Done   = 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout    = rx_dec;
                        Ain     = 1'b1;
                        state_d = S_T2;
                    end
                    default: Done = 1'b1;
                endcase
            end
            S_T2: begin
                Rout    = ry_dec;
                Gin     = 1'b1;
                AddSub  = opcode[0];
                state_d = S_T3;
            end
            S_T3: begin
                Gout = 1'b1;
                Rin  = rx_dec;
                Done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Run is only looked at when an instruction completes
        if (Done) state_d = Run ? S_T0 : S_IDLE;
    end

    always_comb begin
        case (state_q)
            S_T1:    Tstep = 2'b01;
            S_T2:    Tstep = 2'b10;
            S_T3:    Tstep = 2'b11;
            default: Tstep = 2'b00;
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign ADDR = addr_q;

endmodule
